// File: rtl/cache_refill_arbiter.sv
// Round-robin refill sequencer: grants one of two cache miss requests, issues a memory burst
// and steers BEATS line beats to the winner. Optional watchdog enabled by `define REFILL_TIMEOUT_EN.
module cache_refill_arbiter #(
    parameter int LINE_WIDTH = 512,
    parameter int TAG_WIDTH  = 18,
    parameter int BEATS      = 64,
    parameter int BEAT_CNT_W = 6
`ifdef REFILL_TIMEOUT_EN
    ,
    parameter int TIMEOUT_W  = 10
`endif
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  req0,
    input  logic [TAG_WIDTH-1:0]  req0_addr,
    input  logic                  req1,
    input  logic [TAG_WIDTH-1:0]  req1_addr,
    output logic                  mem_req,
    output logic [TAG_WIDTH-1:0]  mem_addr,
    input  logic                  mem_ack,
    input  logic                  mem_beat_valid,
    input  logic [LINE_WIDTH-1:0] mem_beat_data,
    output logic                  fill_valid,
    output logic                  fill_sel,
    output logic [BEAT_CNT_W-1:0] fill_index,
    output logic [LINE_WIDTH-1:0] fill_data,
    output logic                  done0,
    output logic                  done1,
    output logic                  busy,
    output logic                  timeout_err
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_FILL  = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [BEAT_CNT_W-1:0] LAST_BEAT = BEAT_CNT_W'(BEATS - 1);

    state_t                  state_q, state_d;
    logic                    last_grant_q, last_grant_d;
    logic [TAG_WIDTH-1:0]    mem_addr_q, mem_addr_d;
    logic                    mem_req_q, mem_req_d;
    logic [BEAT_CNT_W-1:0]   count_q, count_d;
    logic                    fill_valid_q, fill_valid_d;
    logic                    fill_sel_q, fill_sel_d;
    logic [BEAT_CNT_W-1:0]   fill_index_q, fill_index_d;
    logic [LINE_WIDTH-1:0]   fill_data_q, fill_data_d;
    logic                    done0_q, done0_d;
    logic                    done1_q, done1_d;
    logic                    pick;

`ifdef REFILL_TIMEOUT_EN
    logic [TIMEOUT_W-1:0]    wd_q, wd_d;
    logic                    timeout_err_q, timeout_err_d;
`endif

    // On a tie the requester that did not win last time gets the grant.
    assign pick = (req0 && req1) ? ~last_grant_q : req1;

    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        mem_addr_d   = mem_addr_q;
        mem_req_d    = mem_req_q;
        count_d      = count_q;
        fill_valid_d = 1'b0;
        fill_sel_d   = fill_sel_q;
        fill_index_d = fill_index_q;
        fill_data_d  = fill_data_q;
        done0_d      = 1'b0;
        done1_d      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                if (req0 || req1) begin
                    last_grant_d = pick;
                    mem_addr_d   = pick ? req1_addr : req0_addr;
                    mem_req_d    = 1'b1;
                    state_d      = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (mem_ack) begin
                    mem_req_d = 1'b0;
                    state_d   = ST_FILL;
                end
            end
            ST_FILL: begin
                if (mem_beat_valid) begin
                    fill_valid_d = 1'b1;
                    fill_sel_d   = last_grant_q;
                    fill_index_d = count_q;
                    fill_data_d  = mem_beat_data;
                    count_d      = count_q + 1'b1;
                    if (count_q == LAST_BEAT) begin
                        state_d = ST_DONE;
                        done0_d = ~last_grant_q;
                        done1_d = last_grant_q;
                    end
                end
            end
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

`ifdef REFILL_TIMEOUT_EN
        // Watchdog restarts on every ack or beat; expiry abandons the burst without a done pulse.
        wd_d          = '0;
        timeout_err_d = 1'b0;
        if ((state_q == ST_ISSUE && !mem_ack) || (state_q == ST_FILL && !mem_beat_valid)) begin
            if (wd_q == '1) begin
                timeout_err_d = 1'b1;
                mem_req_d     = 1'b0;
                count_d       = '0;
                state_d       = ST_IDLE;
            end else begin
                wd_d = wd_q + 1'b1;
            end
        end
`endif
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            last_grant_q <= 1'b1;
            mem_addr_q   <= '0;
            mem_req_q    <= 1'b0;
            count_q      <= '0;
            fill_valid_q <= 1'b0;
            fill_sel_q   <= 1'b0;
            fill_index_q <= '0;
            fill_data_q  <= '0;
            done0_q      <= 1'b0;
            done1_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            mem_addr_q   <= mem_addr_d;
            mem_req_q    <= mem_req_d;
            count_q      <= count_d;
            fill_valid_q <= fill_valid_d;
            fill_sel_q   <= fill_sel_d;
            fill_index_q <= fill_index_d;
            fill_data_q  <= fill_data_d;
            done0_q      <= done0_d;
            done1_q      <= done1_d;
        end
    end

`ifdef REFILL_TIMEOUT_EN
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wd_q          <= '0;
            timeout_err_q <= 1'b0;
        end else begin
            wd_q          <= wd_d;
            timeout_err_q <= timeout_err_d;
        end
    end

    assign timeout_err = timeout_err_q;
`else
    assign timeout_err = 1'b0;
`endif

    assign mem_req    = mem_req_q;
    assign mem_addr   = mem_addr_q;
    assign fill_valid = fill_valid_q;
    assign fill_sel   = fill_sel_q;
    assign fill_index = fill_index_q;
    assign fill_data  = fill_data_q;
    assign done0      = done0_q;
    assign done1      = done1_q;
    assign busy       = (state_q != ST_IDLE);

endmodule
